enigma_sequencer: RTL and testbench

ENIGMA_SEQUENCER -- requirements
Module: enigma_sequencer

---
 rtl/enigma_pkg.sv | 63 ++++++
 rtl/enigma_wiring_lut.sv | 34 +++
 rtl/enigma_sequencer.sv | 130 +++++++++++++
 tb/tb_enigma_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// rtl/enigma_pkg.sv - Enigma sequencer letters, rotor codes, notch/wiring tables, FSM encoding
package enigma_pkg;

    typedef enum logic [4:0] {
        LTR_A, LTR_B, LTR_C, LTR_D, LTR_E, LTR_F, LTR_G, LTR_H, LTR_I,
        LTR_J, LTR_K, LTR_L, LTR_M, LTR_N, LTR_O, LTR_P, LTR_Q, LTR_R,
        LTR_S, LTR_T, LTR_U, LTR_V, LTR_W, LTR_X, LTR_Y, LTR_Z
    } letter_t;

    localparam logic [1:0] ROTOR_I    = 2'b00;
    localparam logic [1:0] ROTOR_II   = 2'b01;
    localparam logic [1:0] ROTOR_III  = 2'b10;
    localparam logic [1:0] ROTOR_PASS = 2'b11;

    localparam logic [4:0] NOTCH_I   = LTR_Q;
    localparam logic [4:0] NOTCH_II  = LTR_E;
    localparam logic [4:0] NOTCH_III = LTR_V;

    // Tables are ASCII strings; entry 0 sits in the top byte.
    localparam logic [8*26-1:0] WIRING_I    = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
    localparam logic [8*26-1:0] WIRING_II   = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
    localparam logic [8*26-1:0] WIRING_III  = "BDFHJLCPRTXVZNYEWIGAKMUSQO";
    localparam logic [8*26-1:0] REFLECTOR_B = "YRUHQSLDPXNGOKMIEBFZCWVJAT";

    typedef enum logic [3:0] {
        IDLE, STEP, FWD_R, FWD_M, FWD_L, REFL, REV_L, REV_M, REV_R, DONE
    } state_t;

    function automatic logic [4:0] add_mod26(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 6'd26) s = s - 6'd26;
        return s[4:0];
    endfunction

    function automatic logic [4:0] sub_mod26(input logic [4:0] a, input logic [4:0] b);
        logic [4:0] d;
        if (a >= b) d = a - b;
        else        d = a + 5'd26 - b;
        return d;
    endfunction

    function automatic logic at_notch(input logic [1:0] rotor_type, input logic [4:0] pos);
        logic hit;
        case (rotor_type)
            ROTOR_I:   hit = (pos == NOTCH_I);
            ROTOR_II:  hit = (pos == NOTCH_II);
            ROTOR_III: hit = (pos == NOTCH_III);
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

    function automatic logic [4:0] table_lookup(input logic [8*26-1:0] tbl, input logic [4:0] idx);
        logic [7:0] ch;
        ch = 8'd65;
        for (int i = 0; i < 26; i++) begin
            if (idx == 5'(i)) ch = tbl[8*(25-i) +: 8];
        end
        return 5'(ch - 8'd65);
    endfunction

endpackage

// File: rtl/enigma_wiring_lut.sv
// rtl/enigma_wiring_lut.sv - shared rotor/reflector wiring lookup, sel = {reflector, inverse, type}
module enigma_wiring_lut
    import enigma_pkg::*;
(
    input  logic [3:0] sel,
    input  logic [4:0] idx,
    output logic [4:0] wired_idx
);

    logic [8*26-1:0] tbl;

    always_comb begin
        case (sel[1:0])
            ROTOR_I:  tbl = WIRING_I;
            ROTOR_II: tbl = WIRING_II;
            default:  tbl = WIRING_III;
        endcase

        wired_idx = idx;
        if (sel[3]) begin
            wired_idx = table_lookup(REFLECTOR_B, idx);
        end else if (sel[1:0] == ROTOR_PASS) begin
            wired_idx = idx;
        end else if (!sel[2]) begin
            wired_idx = table_lookup(tbl, idx);
        end else begin
            // Inverse wiring: search for the contact that maps onto idx.
            for (int i = 0; i < 26; i++) begin
                if (table_lookup(tbl, 5'(i)) == idx) wired_idx = 5'(i);
            end
        end
    end

endmodule

// File: rtl/enigma_sequencer.sv
// rtl/enigma_sequencer.sv - three-rotor Enigma letter sequencer; DOUBLE_STEP_EN selects double-step stepping
module enigma_sequencer
    import enigma_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic       key_valid,
    input  logic [4:0] key_code,
    output logic       key_ready,
    output logic       out_valid,
    output logic [4:0] out_code,
    input  logic       out_ready,
    input  logic       cfg_load,
    input  logic [1:0] cfg_rotor_l,
    input  logic [1:0] cfg_rotor_m,
    input  logic [1:0] cfg_rotor_r,
    input  logic [4:0] cfg_pos_l,
    input  logic [4:0] cfg_pos_m,
    input  logic [4:0] cfg_pos_r,
    output logic [4:0] pos_l,
    output logic [4:0] pos_m,
    output logic [4:0] pos_r,
    output logic       key_err
);

    state_t     state, state_next;
    logic [1:0] type_l, type_m, type_r;
    logic [4:0] letter;
    logic       ready_en;
    logic       cfg_take, key_take, key_good;
    logic       notch_r, notch_m, step_m, step_l, in_pass;
    logic [3:0] lut_sel;
    logic [4:0] lut_pos, lut_in, lut_out, pass_out;

    assign cfg_take  = (state == IDLE) && cfg_load;
    assign key_ready = (state == IDLE) && ready_en && !cfg_load;
    assign key_take  = key_valid && key_ready;
    assign key_good  = key_code <= 5'd25;
    assign out_valid = (state == DONE);
    assign out_code  = out_valid ? letter : 5'd0;
    assign in_pass   = state inside {FWD_R, FWD_M, FWD_L, REFL, REV_L, REV_M, REV_R};

    assign notch_r = at_notch(type_r, pos_r);
    assign notch_m = at_notch(type_m, pos_m);
`ifdef DOUBLE_STEP_EN
    assign step_m = notch_r || notch_m;
    assign step_l = notch_m;
`else
    assign step_m = notch_r;
    assign step_l = notch_m && notch_r;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (key_take && key_good) state_next = STEP;
            STEP:    state_next = FWD_R;
            FWD_R:   state_next = FWD_M;
            FWD_M:   state_next = FWD_L;
            FWD_L:   state_next = REFL;
            REFL:    state_next = REV_L;
            REV_L:   state_next = REV_M;
            REV_M:   state_next = REV_R;
            REV_R:   state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One lookup serves all seven passes; the rotor offset is applied around it.
    always_comb begin
        lut_sel = {2'b00, type_r};
        lut_pos = pos_r;
        case (state)
            FWD_M:   begin lut_sel = {2'b00, type_m}; lut_pos = pos_m; end
            FWD_L:   begin lut_sel = {2'b00, type_l}; lut_pos = pos_l; end
            REFL:    begin lut_sel = 4'b1000;         lut_pos = 5'd0;  end
            REV_L:   begin lut_sel = {2'b01, type_l}; lut_pos = pos_l; end
            REV_M:   begin lut_sel = {2'b01, type_m}; lut_pos = pos_m; end
            REV_R:   begin lut_sel = {2'b01, type_r}; lut_pos = pos_r; end
            default: begin lut_sel = {2'b00, type_r}; lut_pos = pos_r; end
        endcase
    end

    assign lut_in   = add_mod26(letter, lut_pos);
    assign pass_out = sub_mod26(lut_out, lut_pos);

    enigma_wiring_lut u_wiring_lut (
        .sel       (lut_sel),
        .idx       (lut_in),
        .wired_idx (lut_out)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pos_l    <= 5'd0;
            pos_m    <= 5'd0;
            pos_r    <= 5'd0;
            type_l   <= ROTOR_I;
            type_m   <= ROTOR_II;
            type_r   <= ROTOR_III;
            letter   <= 5'd0;
            key_err  <= 1'b0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            key_err  <= key_take && !key_good;
            if (cfg_take) begin
                type_l <= cfg_rotor_l;
                type_m <= cfg_rotor_m;
                type_r <= cfg_rotor_r;
                pos_l  <= cfg_pos_l;
                pos_m  <= cfg_pos_m;
                pos_r  <= cfg_pos_r;
            end else if (state == STEP) begin
                pos_r <= add_mod26(pos_r, 5'd1);
                if (step_m) pos_m <= add_mod26(pos_m, 5'd1);
                if (step_l) pos_l <= add_mod26(pos_l, 5'd1);
            end
            if (key_take && key_good) letter <= key_code;
            else if (in_pass)         letter <= pass_out;
        end
    end

endmodule

// File: tb/tb_enigma_sequencer.sv
// tb/tb_enigma_sequencer.sv - directed self-checking bench for enigma_sequencer
`timescale 1ns/1ps
module tb_enigma_sequencer;

    logic       clock = 1'b0;
    logic       resetn;
    logic       key_valid;
    logic [4:0] key_code;
    logic       key_ready;
    logic       out_valid;
    logic [4:0] out_code;
    logic       out_ready;
    logic       cfg_load;
    logic [1:0] cfg_rotor_l, cfg_rotor_m, cfg_rotor_r;
    logic [4:0] cfg_pos_l, cfg_pos_m, cfg_pos_r;
    logic [4:0] pos_l, pos_m, pos_r;
    logic       key_err;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef DOUBLE_STEP_EN
    localparam logic [4:0] EXP3_L = 5'd1;
    localparam logic [4:0] EXP3_M = 5'd5;
`else
    localparam logic [4:0] EXP3_L = 5'd0;
    localparam logic [4:0] EXP3_M = 5'd4;
`endif

    enigma_sequencer dut (
        .clock       (clock),
        .resetn      (resetn),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_ready   (key_ready),
        .out_valid   (out_valid),
        .out_code    (out_code),
        .out_ready   (out_ready),
        .cfg_load    (cfg_load),
        .cfg_rotor_l (cfg_rotor_l),
        .cfg_rotor_m (cfg_rotor_m),
        .cfg_rotor_r (cfg_rotor_r),
        .cfg_pos_l   (cfg_pos_l),
        .cfg_pos_m   (cfg_pos_m),
        .cfg_pos_r   (cfg_pos_r),
        .pos_l       (pos_l),
        .pos_m       (pos_m),
        .pos_r       (pos_r),
        .key_err     (key_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_pos(input string tag, input logic [4:0] l, input logic [4:0] m, input logic [4:0] r);
        check($sformatf("%s pos_l", tag), 8'(pos_l), 8'(l));
        check($sformatf("%s pos_m", tag), 8'(pos_m), 8'(m));
        check($sformatf("%s pos_r", tag), 8'(pos_r), 8'(r));
    endtask

    task automatic load_cfg(input logic [1:0] rl, input logic [1:0] rm, input logic [1:0] rr,
                            input logic [4:0] pl, input logic [4:0] pm, input logic [4:0] pr);
        cfg_rotor_l = rl; cfg_rotor_m = rm; cfg_rotor_r = rr;
        cfg_pos_l = pl; cfg_pos_m = pm; cfg_pos_r = pr;
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
    endtask

    task automatic send_key(input string tag, input logic [4:0] code);
        int n;
        n = 0;
        while (!key_ready && n < 20) begin tick(); n++; end
        check($sformatf("%s key_ready", tag), 8'(key_ready), 8'd1);
        key_valid = 1'b1;
        key_code  = code;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
        check($sformatf("%s latency", tag), 8'(n), 8'd8);
    endtask

    task automatic encrypt(input string tag, input logic [4:0] code, input logic [4:0] exp);
        send_key(tag, code);
        wait_out(tag);
        check($sformatf("%s out_code", tag), 8'(out_code), 8'(exp));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check($sformatf("%s out_valid drop", tag), 8'(out_valid), 8'd0);
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            if (out_valid) seen++;
            tick();
        end
        check($sformatf("%s no out_valid", tag), 8'(seen), 8'd0);
    endtask

    initial begin
        resetn = 1'b0; key_valid = 1'b0; key_code = 5'd0; out_ready = 1'b0; cfg_load = 1'b0;
        cfg_rotor_l = 2'b00; cfg_rotor_m = 2'b00; cfg_rotor_r = 2'b00;
        cfg_pos_l = 5'd0; cfg_pos_m = 5'd0; cfg_pos_r = 5'd0;

        // Reset values and first ready edge
        #1;
        check("rst key_ready", 8'(key_ready), 8'd0);
        check("rst out_valid", 8'(out_valid), 8'd0);
        check("rst out_code", 8'(out_code), 8'd0);
        check("rst key_err", 8'(key_err), 8'd0);
        tick(); tick();
        check_pos("rst", 5'd0, 5'd0, 5'd0);
        resetn = 1'b1;
        #1;
        check("release key_ready before edge", 8'(key_ready), 8'd0);
        tick();
        check("release key_ready after edge", 8'(key_ready), 8'd1);

        // I-II-III at AAA, AAAAA -> BDZGO
        load_cfg(2'b00, 2'b01, 2'b10, 5'd0, 5'd0, 5'd0);
        encrypt("aaa k1", 5'd0, 5'd1);
        encrypt("aaa k2", 5'd0, 5'd3);
        encrypt("aaa k3", 5'd0, 5'd25);
        encrypt("aaa k4", 5'd0, 5'd6);
        encrypt("aaa k5", 5'd0, 5'd14);
        check_pos("aaa end", 5'd0, 5'd0, 5'd5);

        // Stepping across the right and middle notches from ADU
        load_cfg(2'b00, 2'b01, 2'b10, 5'd0, 5'd3, 5'd20);
        send_key("adu k1", 5'd0); wait_out("adu k1");
        check_pos("adu k1", 5'd0, 5'd3, 5'd21);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        send_key("adu k2", 5'd0); wait_out("adu k2");
        check_pos("adu k2", 5'd0, 5'd4, 5'd22);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        send_key("adu k3", 5'd0); wait_out("adu k3");
        check_pos("adu k3", EXP3_L, EXP3_M, 5'd23);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // Out-of-range key code
        key_valid = 1'b1; key_code = 5'd27;
        tick();
        key_valid = 1'b0;
        check("bad key_err pulse", 8'(key_err), 8'd1);
        check("bad key_ready", 8'(key_ready), 8'd1);
        tick();
        check("bad key_err clear", 8'(key_err), 8'd0);
        expect_quiet("bad", 10);
        check_pos("bad", EXP3_L, EXP3_M, 5'd23);

        // cfg_load wins over a simultaneous key
        cfg_rotor_l = 2'b00; cfg_rotor_m = 2'b01; cfg_rotor_r = 2'b10;
        cfg_pos_l = 5'd0; cfg_pos_m = 5'd0; cfg_pos_r = 5'd0;
        cfg_load = 1'b1; key_valid = 1'b1; key_code = 5'd0;
        #1;
        check("prio key_ready", 8'(key_ready), 8'd0);
        tick();
        cfg_load = 1'b0; key_valid = 1'b0;
        check_pos("prio", 5'd0, 5'd0, 5'd0);
        expect_quiet("prio", 10);

        // Back-pressure holds the result
        send_key("stall", 5'd0);
        wait_out("stall");
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall %0d out_valid", i), 8'(out_valid), 8'd1);
            check($sformatf("stall %0d out_code", i), 8'(out_code), 8'd1);
            check($sformatf("stall %0d key_ready", i), 8'(key_ready), 8'd0);
            tick();
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        check("stall done", 8'(out_valid), 8'd0);
        check_pos("stall", 5'd0, 5'd0, 5'd1);

        // Reset while the letter is in the reflector pass
        load_cfg(2'b00, 2'b01, 2'b10, 5'd3, 5'd4, 5'd5);
        send_key("midrst", 5'd0);
        tick(); tick(); tick(); tick();
        resetn = 1'b0;
        #1;
        check("midrst out_valid", 8'(out_valid), 8'd0);
        check("midrst key_ready", 8'(key_ready), 8'd0);
        check_pos("midrst", 5'd0, 5'd0, 5'd0);
        tick(); tick();
        resetn = 1'b1;
        tick();
        check("midrst key_ready after", 8'(key_ready), 8'd1);
        expect_quiet("midrst", 12);
        check_pos("midrst after", 5'd0, 5'd0, 5'd0);
        encrypt("midrst default rotors", 5'd0, 5'd1);

        // All passthrough rotors expose the bare reflector
        load_cfg(2'b11, 2'b11, 2'b11, 5'd0, 5'd0, 5'd0);
        encrypt("pass H", 5'd7, 5'd3);
        check_pos("pass", 5'd0, 5'd0, 5'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
